fpu_add_sched: RTL and testbench
================================

# fpu_add_sched

Two-port scheduler for the shared iterative floating-point adder `fpu_add`. It arbitrates between two requesters, for example the integer-pipe and FP-pipe issue slots. It classifies the winning operands into the adder's special-case flags and holds them stable while `fpu_add` normalises. It then returns the 35-bit result (sign, exp, 25-bit mantissa, sticky) with a valid/ready handshake. One operation is in flight at a time. `fpu_add` is instantiated inside this block.

## Interface
- `TIMEOUT`, default 63: normalisation cycle limit before abort; 6-bit counter.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset. Also drives the internal `fpu_add` `rst`.
- `req_valid`  in  2  per-requester request valid.
- `req_ready`  out  2  per-requester accept; one-hot or zero.
- `req_opa`  in  2x32  operand A per requester, IEEE-754 single.
- `req_opb`  in  2x32  operand B per requester.
- `req_fsub`  in  2  1 = A−B, 0 = A+B.
- `resp_valid`  out  1  result available.
- `resp_ready`  in  1  consumer accepts result.
- `resp_id`  out  1  index of the requester that owns the result.
- `resp_data`  out  35  `fpu_add` output format.
- `resp_err`  out  1  timeout abort; `resp_data` = canonical NaN.

## Operation
- FSM states: IDLE, LAUNCH, WAIT, RESP.
- IDLE:
  - `req_ready[g]` = 1 for the granted index g when `req_valid[g]`.
  - On handshake, register opa, opb, fsub and id, register the classify flags, then go to LAUNCH.
- LAUNCH (1 cycle): drive `new_input` = 1, clear the timeout counter, then go to WAIT.
- WAIT:
  - Hold the registered operands and flags on the `fpu_add` inputs; `new_input` = 0.
  - When `fpu_add.busy` = 0, capture `fpu_add.out` into the result register, set `resp_err` = 0, then go to RESP.
  - Otherwise increment the counter. When the counter reaches `TIMEOUT`, capture `{1'b0, 8'hff, 23'h400000, 3'b000}`, set `resp_err` = 1, then go to RESP.
- RESP:
  - `resp_valid` = 1 with `resp_data`, `resp_id` and `resp_err` stable.
  - On `resp_ready`, go to IDLE.
  - No new grant while in RESP. Requests are first accepted in the IDLE cycle that follows.
- Classification, computed on the registered operands. Flags are mutually exclusive:
  - `nan_fl` = any operand with exp = FF and mant ≠ 0.
  - `two_inf_fl` = both operands infinite and not `nan_fl`.
  - `one_inf_fl` = exactly one operand infinite and not `nan_fl`.
  - `z_fl` = any operand ±0 and none of the above.
- Arbitration: fixed priority, requester 0 over requester 1, unless `FPU_ADD_RR_EN` is defined.
- Reset mid-operation: next state IDLE, the in-flight operation and any held result are discarded, and the adder is reset in the same cycle.

## Timing
- Reset values: `req_ready` = 0 (combinational from IDLE, so 0 during `rst`), `resp_valid` = 0, `resp_id` = 0, `resp_data` = 0, `resp_err` = 0. State = IDLE, counter = 0, RR pointer = 0.
- Accept in cycle T:
  - LAUNCH in T+1.
  - First WAIT evaluation in T+2.
  - Special case or immediate carry: `resp_valid` at T+3.
- Each normalisation shift adds 1 cycle. Timeout gives `resp_valid` at T+3+`TIMEOUT`.
- `req_ready` is combinational from state and `req_valid`. There is no combinational path from `resp_ready` to `req_ready`.
- `resp_valid` with `resp_ready` in the same cycle: the block is in IDLE the next cycle, giving 1 bubble between back-to-back operations.

## Configuration
- `FPU_ADD_RR_EN` defined: round-robin arbitration.
  - A 1-bit pointer names the preferred requester.
  - After each grant to i, the pointer becomes 1−i.
  - With both requesters valid, grants alternate.
- `FPU_ADD_RR_EN` undefined: requester 0 always wins, and the pointer register is absent.

## Structure
- Shared package `fpu_pkg`:
  - `sched_state_t` enum.
  - Constants `FP_EXP_MAX` = 8'hFF and `FP_QNAN35`.
  - Typedef `fpu_res_t` = logic [34:0].
- Sub-module `fpu_add_classify`: combinational; inputs opa, opb; outputs the four flags. It is reusable by the multiplier scheduler.
- `fpu_add` is instantiated once inside `fpu_add_sched`.

## Test plan
- Req0: 3F800000 + 40000000, fsub = 0 -> `resp_valid` with `resp_data[34:3]` = 40400000, `resp_id` = 0, `resp_err` = 0.
- Req1 alone: 3F800001 − 3F800000 -> `resp_id` = 1, result exponent lowered through multi-cycle normalisation, latency > 3 cycles and ≤ 3 + `TIMEOUT`.
- Both valid on back-to-back operations -> grant order 0,0 without the macro; 0,1 with `FPU_ADD_RR_EN`. `req_ready` is never 2'b11.
- 7FC00000 + 3F800000 -> `nan_fl` only, `resp_valid` at T+3, `resp_data[34:3]` = 7FC00000. 7F800000 − 7F800000 -> `two_inf_fl`, NaN output.
- `resp_ready` held 0 for 10 cycles -> `resp_data` and `resp_id` stable, `req_ready` = 0 throughout.
- `rst` asserted in WAIT -> next cycle IDLE, `resp_valid` = 0, and a new request is accepted and completes correctly.

Source files
------------

// File: rtl/fpu_pkg.sv
// fpu_pkg: shared types and constants for the FP adder scheduler and its adder.
package fpu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} sched_state_t;
  typedef logic [34:0] fpu_res_t;
  localparam logic [7:0] FP_EXP_MAX = 8'hFF;
  localparam fpu_res_t FP_QNAN35 = {1'b0, 8'hff, 23'h400000, 3'b000};
  // {carry, hidden, fraction[22:0], guard, round, sticky}
  function automatic logic [27:0] fp_mant28(input logic [31:0] x);
    return {1'b0, |x[30:23], x[22:0], 3'b000};
  endfunction
endpackage

// File: rtl/fpu_add.sv
// fpu_add: iterative FP adder; aligns and adds on new_input, then left-normalises one bit per cycle while busy.
module fpu_add
  import fpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        new_input,
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  input  logic        fsub,
  input  logic        nan_fl,
  input  logic        two_inf_fl,
  input  logic        one_inf_fl,
  input  logic        z_fl,
  output logic        busy,
  output fpu_res_t    out
);
  logic sa, sb, za, zb, swap, sl, lost, pick_a, r_s, r_busy;
  logic [7:0] el, es, d, r_e;
  logic [27:0] ml, ms, msh, sum, r_m;
  logic [31:0] ps;
  logic s_q, busy_q;
  logic [7:0] e_q;
  logic [27:0] m_q;
  always_comb begin
    sa     = opa[31];
    sb     = opb[31] ^ fsub;
    za     = ~|opa[30:0];
    zb     = ~|opb[30:0];
    swap   = opb[30:0] > opa[30:0];
    sl     = swap ? sb : sa;
    el     = swap ? opb[30:23] : opa[30:23];
    es     = swap ? opa[30:23] : opb[30:23];
    ml     = swap ? fp_mant28(opb) : fp_mant28(opa);
    ms     = swap ? fp_mant28(opa) : fp_mant28(opb);
    d      = el - es;
    msh    = d > 8'd27 ? '0 : ms >> d;
    lost   = d > 8'd27 ? |ms : |(ms & ~(28'hfffffff << d));
    sum    = (sa ^ sb) ? ml - (msh | 28'(lost)) : ml + (msh | 28'(lost));
    pick_a = one_inf_fl ? opa[30:23] == FP_EXP_MAX : !za;
    ps     = pick_a ? opa : opb;
    r_s    = sum == '0 ? 1'b0 : sl;
    r_e    = sum == '0 ? 8'd0 : sum[27] ? el + 8'd1 : el;
    r_m    = sum[27] ? {1'b0, sum[27:2], sum[1] | sum[0]} : sum;
    if (sum[27] && r_e == FP_EXP_MAX) r_m = 28'h4000000;
    if (nan_fl || (two_inf_fl && sa != sb)) begin
      r_s = 1'b0;
      r_e = FP_EXP_MAX;
      r_m = 28'h6000000;
    end else if (two_inf_fl) begin
      r_s = sa;
      r_e = FP_EXP_MAX;
      r_m = 28'h4000000;
    end else if (one_inf_fl || z_fl) begin
      r_s = (za && zb) ? sa & sb : pick_a ? sa : sb;
      r_e = ps[30:23];
      r_m = fp_mant28(ps);
    end
    r_busy = r_m != '0 && !r_m[26] && r_e > 8'd1;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      s_q    <= 1'b0;
      e_q    <= '0;
      m_q    <= '0;
      busy_q <= 1'b0;
    end else if (new_input) begin
      s_q    <= r_s;
      e_q    <= r_e;
      m_q    <= r_m;
      busy_q <= r_busy;
    end else if (busy_q) begin
      m_q    <= m_q << 1;
      e_q    <= e_q - 8'd1;
      busy_q <= !m_q[25] && e_q > 8'd2;
    end
  end
  assign busy = busy_q;
  assign out  = {s_q, e_q, m_q[25:0]};
endmodule

// File: rtl/fpu_add_classify.sv
// fpu_add_classify: mutually exclusive special-case flags for an IEEE-754 single operand pair.
module fpu_add_classify
  import fpu_pkg::*;
(
  input  logic [31:0] opa,
  input  logic [31:0] opb,
  output logic        nan_fl,
  output logic        two_inf_fl,
  output logic        one_inf_fl,
  output logic        z_fl
);
  logic ea_max, eb_max, ia, ib;
  always_comb begin
    ea_max     = opa[30:23] == FP_EXP_MAX;
    eb_max     = opb[30:23] == FP_EXP_MAX;
    ia         = ea_max && ~|opa[22:0];
    ib         = eb_max && ~|opb[22:0];
    nan_fl     = (ea_max && |opa[22:0]) || (eb_max && |opb[22:0]);
    two_inf_fl = ia && ib && !nan_fl;
    one_inf_fl = (ia ^ ib) && !nan_fl;
    z_fl       = (~|opa[30:0] || ~|opb[30:0]) && !nan_fl && !ia && !ib;
  end
endmodule

// File: rtl/fpu_add_sched.sv
// fpu_add_sched: two-port scheduler for the shared iterative fpu_add with valid/ready result return.
// Define FPU_ADD_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module fpu_add_sched
  import fpu_pkg::*;
#(
  parameter int TIMEOUT = 63
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       req_valid,
  output logic [1:0]       req_ready,
  input  logic [1:0][31:0] req_opa,
  input  logic [1:0][31:0] req_opb,
  input  logic [1:0]       req_fsub,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_id,
  output fpu_res_t         resp_data,
  output logic             resp_err
);
  sched_state_t state_q, state_d;
  logic [31:0] opa_q, opb_q;
  logic fsub_q, id_q, err_q, gnt, accept, busy, new_input, timeout;
  logic nan_c, ti_c, oi_c, z_c;
  logic [3:0] fl_q;
  logic [5:0] cnt_q;
  fpu_res_t res_q, add_out;
`ifdef FPU_ADD_RR_EN
  logic rr_q;
  assign gnt = req_valid[rr_q] ? rr_q : ~rr_q;
  always_ff @(posedge clk) rr_q <= rst ? 1'b0 : accept ? ~gnt : rr_q;
`else
  assign gnt = ~req_valid[0];
`endif
  fpu_add_classify u_cls (
    .opa        (req_opa[gnt]),
    .opb        (req_opb[gnt]),
    .nan_fl     (nan_c),
    .two_inf_fl (ti_c),
    .one_inf_fl (oi_c),
    .z_fl       (z_c)
  );
  fpu_add u_add (
    .clk        (clk),
    .rst        (rst),
    .new_input  (new_input),
    .opa        (opa_q),
    .opb        (opb_q),
    .fsub       (fsub_q),
    .nan_fl     (fl_q[3]),
    .two_inf_fl (fl_q[2]),
    .one_inf_fl (fl_q[1]),
    .z_fl       (fl_q[0]),
    .busy       (busy),
    .out        (add_out)
  );
  always_ff @(posedge clk) state_q <= rst ? S_IDLE : state_d;
  always_comb begin
    timeout = busy && cnt_q == 6'(TIMEOUT);
    state_d = state_q;
    case (state_q)
      S_IDLE:   state_d = accept ? S_LAUNCH : S_IDLE;
      S_LAUNCH: state_d = S_WAIT;
      S_WAIT:   state_d = (!busy || timeout) ? S_RESP : S_WAIT;
      S_RESP:   state_d = resp_ready ? S_IDLE : S_RESP;
    endcase
  end
  always_comb begin
    accept     = state_q == S_IDLE && |req_valid && !rst;
    req_ready  = accept ? 2'b01 << gnt : 2'b00;
    new_input  = state_q == S_LAUNCH;
    resp_valid = state_q == S_RESP;
    resp_id    = id_q;
    resp_data  = res_q;
    resp_err   = err_q;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      opa_q  <= '0;
      opb_q  <= '0;
      fsub_q <= 1'b0;
      id_q   <= 1'b0;
      fl_q   <= '0;
      cnt_q  <= '0;
      res_q  <= '0;
      err_q  <= 1'b0;
    end else begin
      if (accept) begin
        opa_q  <= req_opa[gnt];
        opb_q  <= req_opb[gnt];
        fsub_q <= req_fsub[gnt];
        id_q   <= gnt;
        fl_q   <= {nan_c, ti_c, oi_c, z_c};
      end
      if (new_input) cnt_q <= '0;
      else if (state_q == S_WAIT && busy && !timeout) cnt_q <= cnt_q + 6'd1;
      if (state_q == S_WAIT && (!busy || timeout)) begin
        res_q <= timeout ? FP_QNAN35 : add_out;
        err_q <= timeout;
      end
    end
  end
endmodule

// File: tb/tb_fpu_add_sched.sv
// tb_fpu_add_sched: directed vectors for fpu_add_sched, plus a short-TIMEOUT instance for the abort path.
module tb_fpu_add_sched;
  import fpu_pkg::*;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid, req_ready, req_fsub, t_req_valid, t_req_ready, t_req_fsub;
  logic [1:0][31:0] req_opa, req_opb, t_req_opa, t_req_opb;
  logic resp_valid, resp_ready, resp_id, resp_err;
  logic t_resp_valid, t_resp_ready, t_resp_id, t_resp_err;
  fpu_res_t resp_data, t_resp_data, hold_d;
  logic hold_id, ok;
  logic [1:0] exp_g [2];
  int n_chk = 0, n_fail = 0, n, lat;
  always #5 clk = ~clk;
  fpu_add_sched dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_opa    (req_opa),
    .req_opb    (req_opb),
    .req_fsub   (req_fsub),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_data  (resp_data),
    .resp_err   (resp_err)
  );
  fpu_add_sched #(.TIMEOUT(3)) dut_t (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (t_req_valid),
    .req_ready  (t_req_ready),
    .req_opa    (t_req_opa),
    .req_opb    (t_req_opb),
    .req_fsub   (t_req_fsub),
    .resp_valid (t_resp_valid),
    .resp_ready (t_resp_ready),
    .resp_id    (t_resp_id),
    .resp_data  (t_resp_data),
    .resp_err   (t_resp_err)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  // Called at a falling edge; returns at the falling edge of the LAUNCH cycle.
  task automatic issue(input string tag, input int id, input logic [31:0] a, b, input logic sub);
    int k = 0;
    req_opa[id] = a;
    req_opb[id] = b;
    req_fsub[id] = sub;
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && k < 20) begin
      @(negedge clk);
      k++;
    end
    chk({tag, "_grant"}, req_ready, 2'b01 << id);
    @(negedge clk);
    req_valid[id] = 1'b0;
  endtask
  task automatic await_resp(input string tag, input logic [31:0] exp_d, input logic exp_id,
                            input logic exp_err, input int lmin, input int lmax);
    lat = 1;
    while (!resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    if (lmin == lmax) chk({tag, "_lat"}, lat, lmin);
    else chk({tag, "_lat_range"}, lat >= lmin && lat <= lmax, 1);
    chk({tag, "_data"}, resp_data[34:3], exp_d);
    chk({tag, "_id"}, resp_id, exp_id);
    chk({tag, "_err"}, resp_err, exp_err);
  endtask
  task automatic consume();
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
  endtask
  task automatic run_op(input string tag, input int id, input logic [31:0] a, b, input logic sub,
                        input logic [31:0] exp_d, input int lmin, input int lmax);
    issue(tag, id, a, b, sub);
    await_resp(tag, exp_d, 1'(id), 1'b0, lmin, lmax);
    consume();
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    rst = 1'b1;
    req_valid = 2'b11;
    req_opa = '0;
    req_opb = '0;
    req_fsub = '0;
    resp_ready = 1'b0;
    t_req_valid = '0;
    t_req_opa = '0;
    t_req_opb = '0;
    t_req_fsub = '0;
    t_resp_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ready", req_ready, 2'b00);
    chk("rst_valid", resp_valid, 0);
    chk("rst_data", resp_data, 0);
    chk("rst_id", resp_id, 0);
    chk("rst_err", resp_err, 0);
    req_valid = 2'b00;
    rst = 1'b0;
    @(negedge clk);
    run_op("add", 0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3, 3);
    run_op("sub_norm", 1, 32'h3F800001, 32'h3F800000, 1'b1, 32'h34000000, 4, 66);
    run_op("neg_norm1", 0, 32'h3F800000, 32'h40000000, 1'b1, 32'hBF800000, 4, 4);
    run_op("carry", 1, 32'h3FC00000, 32'h3FC00000, 1'b0, 32'h40400000, 3, 3);
    run_op("mixed_sign", 0, 32'hC0400000, 32'h3F800000, 1'b0, 32'hC0000000, 3, 3);
    run_op("nan", 1, 32'h7FC00000, 32'h3F800000, 1'b0, 32'h7FC00000, 3, 3);
    run_op("inf_inf", 0, 32'h7F800000, 32'h7F800000, 1'b1, 32'h7FC00000, 3, 3);
    run_op("inf_one", 1, 32'h7F800000, 32'h3F800000, 1'b0, 32'h7F800000, 3, 3);
    run_op("zero", 0, 32'h00000000, 32'h40000000, 1'b0, 32'h40000000, 3, 3);
    run_op("cancel", 1, 32'h40000000, 32'h40000000, 1'b1, 32'h00000000, 3, 3);
    // Stalled consumer: result and id hold, and no request is granted.
    issue("stall", 0, 32'h40000000, 32'h3F800000, 1'b0);
    await_resp("stall", 32'h40400000, 1'b0, 1'b0, 3, 3);
    hold_d = resp_data;
    hold_id = resp_id;
    req_valid = 2'b11;
    ok = 1'b1;
    repeat (10) begin
      @(negedge clk);
      if (resp_data !== hold_d || resp_id !== hold_id || req_ready !== 2'b00 || !resp_valid) ok = 1'b0;
    end
    chk("stall_stable", ok, 1);
    req_valid = 2'b00;
    consume();
    // Both requesters valid across two back-to-back operations.
`ifdef FPU_ADD_RR_EN
    exp_g = '{2'b01, 2'b10};
`else
    exp_g = '{2'b01, 2'b01};
`endif
    req_opa[0] = 32'h3F800000;
    req_opb[0] = 32'h40000000;
    req_opa[1] = 32'h40000000;
    req_opb[1] = 32'h40000000;
    req_fsub = 2'b00;
    req_valid = 2'b11;
    #1;
    for (int k = 0; k < 2; k++) begin
      n = 0;
      while (req_ready == 2'b00 && n < 20) begin
        @(negedge clk);
        n++;
      end
      chk("arb_onehot", $countones(req_ready), 1);
      chk("arb_grant", req_ready, exp_g[k]);
      @(negedge clk);
      await_resp("arb", exp_g[k][1] ? 32'h40800000 : 32'h40400000, exp_g[k][1], 1'b0, 3, 3);
      consume();
      #1;
    end
    req_valid = 2'b00;
    // Reset while the adder is normalising.
    issue("rst_wait", 1, 32'h3F800001, 32'h3F800000, 1'b1);
    repeat (4) @(negedge clk);
    chk("rst_wait_busy", resp_valid, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait_valid", resp_valid, 0);
    chk("rst_wait_id", resp_id, 0);
    chk("rst_wait_data", resp_data, 0);
    run_op("post_rst", 0, 32'h3F800000, 32'h40000000, 1'b0, 32'h40400000, 3, 3);
    // Short-TIMEOUT instance: a long normalisation aborts with canonical NaN.
    t_req_opa[0] = 32'h3F800001;
    t_req_opb[0] = 32'h3F800000;
    t_req_fsub[0] = 1'b1;
    t_req_valid = 2'b01;
    #1;
    chk("to_grant", t_req_ready, 2'b01);
    @(negedge clk);
    t_req_valid = 2'b00;
    lat = 1;
    while (!t_resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("to_lat", lat, 6);
    chk("to_data", t_resp_data, FP_QNAN35);
    chk("to_err", t_resp_err, 1);
    @(negedge clk);
    t_req_opa[1] = 32'h3F800000;
    t_req_opb[1] = 32'h40000000;
    t_req_fsub[1] = 1'b0;
    t_req_valid = 2'b10;
    #1;
    chk("to_ok_grant", t_req_ready, 2'b10);
    @(negedge clk);
    t_req_valid = 2'b00;
    lat = 1;
    while (!t_resp_valid && lat < 100) begin
      @(negedge clk);
      lat++;
    end
    chk("to_ok_lat", lat, 3);
    chk("to_ok_data", t_resp_data[34:3], 32'h40400000);
    chk("to_ok_id", t_resp_id, 1);
    chk("to_ok_err", t_resp_err, 0);
    $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
    $finish;
  end
endmodule
